mips_cpu_regfile_param: RTL and testbench



---
 rtl/mips_cpu_regfile_param.sv | 86 ++++++++
 tb/tb_mips_cpu_regfile_param.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mips_cpu_regfile_param.sv
// Parametrised MIPS32 register file: byte-lane writes, N registered read ports,
// optional write-to-read bypass, per-port hold and a registered debug tap.
module mips_cpu_regfile_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned DEBUG_ADDR = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             write,
  input  logic [ADDR_WIDTH-1:0]            wrAddr,
  input  logic [DATA_WIDTH-1:0]            wrData,
  input  logic [DATA_WIDTH/8-1:0]          wrByteEn,
  input  logic [NUM_READ-1:0]              rdEn,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   rdAddr,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rdData,
  output logic [DATA_WIDTH-1:0]            register_dbg
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] DBG_A = ADDR_WIDTH'(DEBUG_ADDR);

  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("mips_cpu_regfile_param: DATA_WIDTH must be a multiple of 8");
  end
  if ((NUM_READ < 1) || (NUM_READ > 4)) begin : g_bad_ports
    $error("mips_cpu_regfile_param: NUM_READ must be in 1..4");
  end

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] wr_merged;
  logic                  wr_live;
  logic [ADDR_WIDTH-1:0] rd_addr [NUM_READ];
  logic [DATA_WIDTH-1:0] rd_next [NUM_READ];
  logic [DATA_WIDTH-1:0] dbg_next;

  // wr_merged is the post-write contents of wrAddr; it feeds both storage and bypass
  always_comb begin
    wr_merged = regs[wrAddr];
    for (int unsigned b = 0; b < LANES; b++) begin
      if (wrByteEn[b]) wr_merged[b*8 +: 8] = wrData[b*8 +: 8];
    end
    wr_live = write && !((ZERO_REG != 0) && (wrAddr == '0));
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_READ; p++) begin
      rd_addr[p] = rdAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_next[p] = regs[rd_addr[p]];
      if ((ZERO_REG != 0) && (rd_addr[p] == '0))
        rd_next[p] = '0;
      else if ((BYPASS != 0) && wr_live && (rd_addr[p] == wrAddr))
        rd_next[p] = wr_merged;
    end
    dbg_next = regs[DBG_A];
    if ((ZERO_REG != 0) && (DBG_A == '0))
      dbg_next = '0;
    else if ((BYPASS != 0) && wr_live && (DBG_A == wrAddr))
      dbg_next = wr_merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wrAddr] <= wr_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdData       <= '0;
      register_dbg <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_READ; p++) begin
        if (rdEn[p]) rdData[p*DATA_WIDTH +: DATA_WIDTH] <= rd_next[p];
      end
      register_dbg <= dbg_next;
    end
  end

endmodule

// File: tb/tb_mips_cpu_regfile_param.sv
// Directed bench for mips_cpu_regfile_param: one instance with bypass, one without,
// driven by identical stimulus.
module tb_mips_cpu_regfile_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [3:0]  wrByteEn;
  logic [1:0]  rdEn;
  logic [9:0]  rdAddr;
  logic [63:0] rdData, rdData_nb;
  logic [31:0] dbg, dbg_nb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_cpu_regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2),
                           .ZERO_REG(1), .BYPASS(1), .DEBUG_ADDR(2)) u_byp (
    .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
    .wrByteEn(wrByteEn), .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData),
    .register_dbg(dbg));

  mips_cpu_regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2),
                           .ZERO_REG(1), .BYPASS(0), .DEBUG_ADDR(2)) u_nb (
    .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
    .wrByteEn(wrByteEn), .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData_nb),
    .register_dbg(dbg_nb));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    write = 1'b1; wrAddr = a; wrData = d; wrByteEn = be;
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; wrAddr = '0; wrData = '0; wrByteEn = '0;
    rdEn = '0; rdAddr = '0;
    tick();
    reset = 1'b0;
    chk("rst_rd0", rdData[31:0], 32'h0);
    chk("rst_rd1", rdData[63:32], 32'h0);
    chk("rst_dbg", dbg, 32'h0);
    chk("rst_dbg_nb", dbg_nb, 32'h0);

    rdEn = 2'b11; rdAddr = {5'd31, 5'd0};
    tick();
    chk("rst_read_r0", rdData[31:0], 32'h0);
    chk("rst_read_r31", rdData[63:32], 32'h0);

    // write/read latency
    rdEn = 2'b00; wr(5'd5, 32'hDEADBEEF, 4'hF);
    tick();
    write = 1'b0; rdEn = 2'b10; rdAddr = {5'd5, 5'd0};
    tick();
    chk("lat_p1_r5", rdData[63:32], 32'hDEADBEEF);
    chk("lat_p0_hold", rdData[31:0], 32'h0);

    // byte enables
    rdEn = 2'b00; wr(5'd7, 32'h11223344, 4'hF);
    tick();
    wr(5'd7, 32'hAABBCCDD, 4'b0101);
    tick();
    wr(5'd7, 32'hFFFFFFFF, 4'b0000); rdEn = 2'b01; rdAddr = {5'd0, 5'd7};
    tick();
    chk("be_merge_byp", rdData[31:0], 32'h11BB33DD);
    chk("be_merge_nb", rdData_nb[31:0], 32'h11BB33DD);
    write = 1'b0;
    tick();
    chk("be_zero_noop", rdData[31:0], 32'h11BB33DD);

    // bypass collision
    rdEn = 2'b00; wr(5'd9, 32'h1, 4'hF);
    tick();
    wr(5'd9, 32'h2, 4'hF); rdEn = 2'b11; rdAddr = {5'd9, 5'd9};
    tick();
    chk("byp_p0", rdData[31:0], 32'h2);
    chk("byp_p1", rdData[63:32], 32'h2);
    chk("nb_p0_old", rdData_nb[31:0], 32'h1);
    chk("nb_p1_old", rdData_nb[63:32], 32'h1);
    write = 1'b0;
    tick();
    chk("nb_p0_new", rdData_nb[31:0], 32'h2);
    chk("nb_p1_new", rdData_nb[63:32], 32'h2);

    // zero register
    wr(5'd0, 32'hFFFFFFFF, 4'hF); rdAddr = {5'd0, 5'd0};
    tick();
    chk("r0_same_cycle", rdData[31:0], 32'h0);
    write = 1'b0;
    tick();
    chk("r0_after", rdData[63:32], 32'h0);
    chk("r0_after_nb", rdData_nb[31:0], 32'h0);

    // read stall / hold
    rdEn = 2'b01; rdAddr = {5'd0, 5'd5};
    tick();
    chk("stall_load", rdData[31:0], 32'hDEADBEEF);
    rdEn = 2'b00; wr(5'd5, 32'h12345678, 4'hF);
    tick();
    chk("stall_hold1", rdData[31:0], 32'hDEADBEEF);
    write = 1'b0;
    tick();
    chk("stall_hold2", rdData[31:0], 32'hDEADBEEF);
    rdEn = 2'b01;
    tick();
    chk("stall_release", rdData[31:0], 32'h12345678);

    // reset mid-write and debug tap
    reset = 1'b1; wr(5'd2, 32'hCAFEF00D, 4'hF);
    tick();
    chk("rstw_dbg", dbg, 32'h0);
    chk("rstw_rd0", rdData[31:0], 32'h0);
    reset = 1'b0; write = 1'b0; rdEn = 2'b01; rdAddr = {5'd0, 5'd2};
    tick();
    chk("rstw_r2_zero", rdData[31:0], 32'h0);
    rdEn = 2'b00; wr(5'd2, 32'hCAFEF00D, 4'hF);
    tick();
    chk("dbg_bypass", dbg, 32'hCAFEF00D);
    chk("dbg_nb_old", dbg_nb, 32'h0);
    wr(5'd2, 32'h00AA0000, 4'b0100);
    tick();
    chk("dbg_partial", dbg, 32'hCAAAF00D);
    chk("dbg_nb_prev", dbg_nb, 32'hCAFEF00D);
    write = 1'b0;
    tick();
    chk("dbg_nb_final", dbg_nb, 32'hCAAAF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
